calc_sequencer: RTL and testbench

Command-issuing front end for the 8-bit simple calculator (register file + ALU). Accepts 16-bit micro-instructions through a valid/ready queue and drives the calculator's control ports (WEN, RW, RX, RY, DataIn, Sel, Ctrl) one instruction at a time. After each instruction it reads back the destination register through busY and returns the written value and carry on a valid/ready result port. Sits between a host or test controller and the calculator datapath; it is the only driver of the calculator's control inputs.

---
 rtl/calc_sequencer.sv | 156 +++++++++++++++
 tb/tb_calc_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_sequencer.sv
// Front end for the 8-bit register-file calculator: queues micro-instructions and
// sequences each one onto the calculator controls, then reports the written register.
module calc_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_instr,
    input  logic [7:0]  in_data,
    output logic        calc_WEN,
    output logic [2:0]  calc_RW,
    output logic [2:0]  calc_RX,
    output logic [2:0]  calc_RY,
    output logic [7:0]  calc_DataIn,
    output logic        calc_Sel,
    output logic [3:0]  calc_Ctrl,
    input  logic [7:0]  calc_busY,
    input  logic        calc_Carry,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [7:0]  res_data,
    output logic        res_carry,
    output logic [2:0]  res_reg,
    output logic        busy
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ENT_W = 23;

    typedef enum logic [1:0] {IDLE, ISSUE, READ, REPORT} state_t;

    state_t           state, state_nxt;
    logic [ENT_W-1:0] fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic [ENT_W-1:0] ir;
    logic             push, pop, fifo_empty;

    logic [3:0] ir_ctrl;
    logic [2:0] ir_rw, ir_rx, ir_ry;
    logic       ir_sel, ir_wen;
    logic [7:0] ir_data;

    // Entry layout: instruction bits [15:1] above the 8-bit immediate; bit 0 is dropped.
    assign ir_ctrl = ir[22:19];
    assign ir_rw   = ir[18:16];
    assign ir_rx   = ir[15:13];
    assign ir_ry   = ir[12:10];
    assign ir_sel  = ir[9];
    assign ir_wen  = ir[8];
    assign ir_data = ir[7:0];

    assign fifo_empty = (count == '0);
    assign in_ready   = (count < CNT_W'(DEPTH));
    assign push       = in_valid && in_ready;
    assign pop        = (state == IDLE) && !fifo_empty;
    assign busy       = !fifo_empty || (state != IDLE);
    assign res_valid  = (state == REPORT);

    always_ff @(posedge Clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {in_instr[15:1], in_data};
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!fifo_empty) state_nxt = ISSUE;
            ISSUE:   state_nxt = READ;
            READ:    state_nxt = REPORT;
            REPORT:  if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            ir <= '0;
        end else if (pop) begin
            ir <= fifo_mem[rd_ptr];
        end
    end

    // Carry is only meaningful for add/subtract; other ops report 0.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            res_data  <= 8'h00;
            res_carry <= 1'b0;
            res_reg   <= 3'd0;
        end else begin
            if (state == ISSUE) begin
                res_carry <= (ir_ctrl[3:1] == 3'b000) ? calc_Carry : 1'b0;
            end
            if (state == READ) begin
                res_data <= calc_busY;
                res_reg  <= ir_rw;
            end
        end
    end

    // Calculator controls decode from registered state only; READ points busY at RW.
    always_comb begin
        calc_WEN    = 1'b0;
        calc_RW     = 3'd0;
        calc_RX     = 3'd0;
        calc_RY     = 3'd0;
        calc_DataIn = 8'h00;
        calc_Sel    = 1'b0;
        calc_Ctrl   = 4'd0;
        if (state == ISSUE || state == READ) begin
            calc_RW     = ir_rw;
            calc_RX     = ir_rx;
            calc_DataIn = ir_data;
            calc_Sel    = ir_sel;
            calc_Ctrl   = ir_ctrl;
            if (state == ISSUE) begin
                calc_WEN = ir_wen;
                calc_RY  = ir_ry;
            end else begin
                calc_RY  = ir_rw;
            end
        end
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer with a behavioural register-file/ALU calculator.
module tb_calc_sequencer;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic [7:0]  in_data;
    logic        calc_WEN;
    logic [2:0]  calc_RW, calc_RX, calc_RY;
    logic [7:0]  calc_DataIn;
    logic        calc_Sel;
    logic [3:0]  calc_Ctrl;
    logic [7:0]  calc_busY;
    logic        calc_Carry;
    logic        res_valid;
    logic        res_ready;
    logic [7:0]  res_data;
    logic        res_carry;
    logic [2:0]  res_reg;
    logic        busy;

    always #5 Clk = ~Clk;

    calc_sequencer #(.DEPTH(4)) dut (
        .Clk(Clk), .Rst(Rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_data(in_data),
        .calc_WEN(calc_WEN), .calc_RW(calc_RW), .calc_RX(calc_RX), .calc_RY(calc_RY),
        .calc_DataIn(calc_DataIn), .calc_Sel(calc_Sel), .calc_Ctrl(calc_Ctrl),
        .calc_busY(calc_busY), .calc_Carry(calc_Carry),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_carry(res_carry), .res_reg(res_reg), .busy(busy)
    );

    // Calculator: r0 reads as zero, ALU carry from 9-bit sign-extended operands.
    logic [7:0] regs [8];
    logic [7:0] alu_x, alu_y, rd_y;
    logic [8:0] alu_r;

    always_comb begin
        alu_x = (calc_RX == 3'd0) ? 8'h00 : regs[calc_RX];
        rd_y  = (calc_RY == 3'd0) ? 8'h00 : regs[calc_RY];
        alu_y = calc_Sel ? rd_y : calc_DataIn;
        case (calc_Ctrl)
            4'b0000: alu_r = {alu_x[7], alu_x} + {alu_y[7], alu_y};
            4'b0001: alu_r = {alu_x[7], alu_x} - {alu_y[7], alu_y};
            4'b0010: alu_r = {1'b0, alu_x & alu_y};
            4'b0011: alu_r = {1'b0, alu_x | alu_y};
            default: alu_r = {1'b0, alu_y};
        endcase
    end
    assign calc_busY  = rd_y;
    assign calc_Carry = alu_r[8];

    always @(posedge Clk) begin
        if (calc_WEN && calc_RW != 3'd0) regs[calc_RW] <= alu_r[7:0];
    end

    typedef struct packed {
        logic [7:0] d;
        logic       c;
        logic [2:0] r;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   wen_cycles = 0;

    function automatic logic [15:0] mk(input logic [3:0] ctrl, input logic [2:0] rw,
                                       input logic [2:0] rx, input logic [2:0] ry,
                                       input logic sel, input logic wen);
        return {ctrl, rw, rx, ry, sel, wen, 1'b0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every completed result handshake is compared against the queue head.
    always @(negedge Clk) begin
        if (calc_WEN === 1'b1) wen_cycles++;
        if (Rst === 1'b0 && res_valid === 1'b1 && res_ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got data=0x%0h reg=%0d, required no result",
                         res_data, res_reg);
            end else begin
                mon_e = sb.pop_front();
                check("res_data", 32'(res_data), 32'(mon_e.d));
                check("res_carry", 32'(res_carry), 32'(mon_e.c));
                check("res_reg", 32'(res_reg), 32'(mon_e.r));
            end
        end
    end

    task automatic send(input logic [15:0] ins, input logic [7:0] d, input exp_t e,
                        input int budget, output bit ok);
        ok = 1'b0;
        in_instr = ins;
        in_data  = d;
        in_valid = 1'b1;
        for (int i = 0; i < budget && !ok; i++) begin
            if (in_ready) begin
                @(posedge Clk);
                sb.push_back(e);
                ok = 1'b1;
                #1;
            end else begin
                @(posedge Clk);
                #1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send_chk(input string name, input logic [15:0] ins, input logic [7:0] d,
                            input exp_t e);
        bit ok;
        send(ins, d, e, 8, ok);
        check(name, 32'(ok), 32'd1);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(posedge Clk);
            #1;
            n++;
        end
        check(name, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   ok;
        int   w0;
        int   seen;
        exp_t e;

        for (int i = 0; i < 8; i++) regs[i] = 8'h00;
        Rst       = 1'b1;
        in_valid  = 1'b1;
        in_instr  = mk(4'd0, 3'd1, 3'd0, 3'd0, 1'b0, 1'b1);
        in_data   = 8'hAA;
        res_ready = 1'b1;

        // Reset with an instruction offered: nothing may be accepted.
        repeat (2) @(posedge Clk);
        #1;
        Rst      = 1'b0;
        in_valid = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_calc_wen", 32'(calc_WEN), 32'd0);
        check("rst_res_data", 32'(res_data), 32'd0);
        @(posedge Clk);
        #1;
        check("rst_busy_later", 32'(busy), 32'd0);

        // Load immediate r1 = 0x05 with latency checks.
        w0 = wen_cycles;
        e = {8'h05, 1'b0, 3'd1};
        send_chk("load_r1_accept", mk(4'd0, 3'd1, 3'd0, 3'd0, 1'b0, 1'b1), 8'h05, e);
        check("lat_e0_valid", 32'(res_valid), 32'd0);
        @(posedge Clk);
        #1;
        check("lat_issue_wen", 32'(calc_WEN), 32'd1);
        check("lat_issue_rw", 32'(calc_RW), 32'd1);
        check("lat_e1_valid", 32'(res_valid), 32'd0);
        @(posedge Clk);
        #1;
        check("lat_read_wen", 32'(calc_WEN), 32'd0);
        check("lat_read_ry", 32'(calc_RY), 32'd1);
        check("lat_e2_valid", 32'(res_valid), 32'd0);
        @(posedge Clk);
        #1;
        check("lat_e3_valid", 32'(res_valid), 32'd1);
        wait_idle("load_r1_idle", 20);
        check("load_r1_wen_cycles", 32'(wen_cycles - w0), 32'd1);

        // Write to r0 has no effect.
        e = {8'h00, 1'b0, 3'd0};
        send_chk("load_r0_accept", mk(4'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1), 8'h55, e);
        wait_idle("load_r0_idle", 20);

        // Probe r1: no write, current value reported.
        w0 = wen_cycles;
        e = {8'h05, 1'b0, 3'd1};
        send_chk("probe_r1_accept", mk(4'd0, 3'd1, 3'd0, 3'd0, 1'b0, 1'b0), 8'h00, e);
        wait_idle("probe_r1_idle", 20);
        check("probe_wen_cycles", 32'(wen_cycles - w0), 32'd0);

        // Signed add carry: 0x80 + 0x80 and the load of 0x80 itself carries.
        e = {8'h80, 1'b1, 3'd1};
        send_chk("load80_r1", mk(4'd0, 3'd1, 3'd0, 3'd0, 1'b0, 1'b1), 8'h80, e);
        e = {8'h80, 1'b1, 3'd2};
        send_chk("load80_r2", mk(4'd0, 3'd2, 3'd0, 3'd0, 1'b0, 1'b1), 8'h80, e);
        e = {8'h00, 1'b1, 3'd3};
        send_chk("add_r3", mk(4'd0, 3'd3, 3'd1, 3'd2, 1'b1, 1'b1), 8'h00, e);
        e = {8'h80, 1'b0, 3'd3};
        send_chk("and_r3", mk(4'd2, 3'd3, 3'd1, 3'd2, 1'b1, 1'b1), 8'h00, e);
        wait_idle("alu_idle", 60);

        // Backpressure: 5 accepted while results stall, 6th refused until release.
        res_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            e = {8'(k * 17), 1'b0, 3'(k)};
            send(mk(4'd0, 3'(k), 3'd0, 3'd0, 1'b0, 1'b1), 8'(k * 17), e, 4, ok);
            check("bp_accept", 32'(ok), 32'd1);
        end
        e = {8'h66, 1'b0, 3'd6};
        send(mk(4'd0, 3'd6, 3'd0, 3'd0, 1'b0, 1'b1), 8'h66, e, 10, ok);
        check("bp_sixth_refused", 32'(ok), 32'd0);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_res_valid_held", 32'(res_valid), 32'd1);
        check("bp_res_data_held", 32'(res_data), 32'h11);
        res_ready = 1'b1;
        send(mk(4'd0, 3'd6, 3'd0, 3'd0, 1'b0, 1'b1), 8'h66, e, 60, ok);
        check("bp_sixth_accept", 32'(ok), 32'd1);
        wait_idle("bp_idle", 100);

        // Reset during ISSUE of a queued instruction with two more behind it.
        res_ready = 1'b0;
        e = {8'h00, 1'b0, 3'd0};
        send_chk("mid_d", mk(4'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1), 8'h00, e);
        e = {8'h00, 1'b0, 3'd0};
        send_chk("mid_a", mk(4'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1), 8'h77, e);
        e = {8'h99, 1'b1, 3'd4};
        send_chk("mid_b", mk(4'd0, 3'd4, 3'd0, 3'd0, 1'b0, 1'b1), 8'h99, e);
        e = {8'h99, 1'b1, 3'd5};
        send_chk("mid_c", mk(4'd0, 3'd5, 3'd0, 3'd0, 1'b0, 1'b1), 8'h99, e);
        seen = 0;
        while (res_valid !== 1'b1 && seen < 20) begin
            @(posedge Clk);
            #1;
            seen++;
        end
        check("mid_d_valid", 32'(res_valid), 32'd1);
        res_ready = 1'b1;
        @(posedge Clk);
        #1;
        @(posedge Clk);
        #1;
        check("mid_issue_wen", 32'(calc_WEN), 32'd1);
        Rst = 1'b1;
        sb.delete();
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        check("mid_rst_wen", 32'(calc_WEN), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        w0 = wen_cycles;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge Clk);
            #1;
            if (res_valid === 1'b1) seen++;
        end
        check("mid_no_result", 32'(seen), 32'd0);
        check("mid_no_wen", 32'(wen_cycles - w0), 32'd0);
        check("mid_busy_after", 32'(busy), 32'd0);

        // The discarded instructions must not have written r4/r5.
        e = {8'h44, 1'b0, 3'd4};
        send_chk("probe_r4", mk(4'd2, 3'd4, 3'd0, 3'd0, 1'b0, 1'b0), 8'h00, e);
        e = {8'h55, 1'b0, 3'd5};
        send_chk("probe_r5", mk(4'd2, 3'd5, 3'd0, 3'd0, 1'b0, 1'b0), 8'h00, e);
        wait_idle("final_idle", 40);
        @(posedge Clk);
        #1;
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
